// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues word reads to a synchronous instruction
// memory and queues returned words with their PCs for decode (valid/ready).
module fetch_unit #(
  parameter int unsigned            XLEN         = 32,
  parameter logic [XLEN-1:0]        RESET_VECTOR = '0,
  parameter int unsigned            DEPTH        = 2,
  localparam int unsigned           CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  imem_addr_o,
  input  logic [31:0]      imem_rdata_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             halt_i,
  output logic             instr_valid_o,
  output logic [31:0]      instr_o,
  output logic [XLEN-1:0]  instr_pc_o,
  input  logic             instr_ready_i,
  output logic [CNT_W-1:0] count_o,
  output logic             idle_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]  r_pc;
  logic             r_inflight;
  logic [XLEN-1:0]  r_inflight_pc;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [31:0]      r_buf_instr [DEPTH];
  logic [XLEN-1:0]  r_buf_pc    [DEPTH];

  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [CNT_W:0]   w_occ;

  // Occupancy seen by the issue rule counts the in-flight word and credits a
  // head pop this cycle, so the buffer can never be over-committed.
  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_valid = (r_count != '0);
    w_pop   = w_valid && instr_ready_i;
    w_push  = rstn_i && r_inflight && !redirect_i;
    w_occ   = {1'b0, r_count} + (CNT_W + 1)'(r_inflight) - (CNT_W + 1)'(w_pop);
    w_issue = rstn_i && !redirect_i && !halt_i && (w_occ < (CNT_W + 1)'(DEPTH));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_pc          <= RESET_VECTOR;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
      if (redirect_i) begin
        r_pc     <= {redirect_pc_i[XLEN-1:2], 2'b00};
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_issue) r_pc     <= r_pc + XLEN'(4);
        if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
    end
  end

  // NOTE: buffer storage is deliberately not reset; the reset pointers and count make stale entries unreachable.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= imem_rdata_i;
      r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

  assign imem_req_o    = w_issue;
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? r_buf_instr[r_rd_ptr] : '0;
  assign instr_pc_o    = w_valid ? r_buf_pc[r_rd_ptr]    : '0;
  assign count_o       = r_count;
  assign idle_o        = rstn_i && halt_i && !w_valid && !r_inflight;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory model returns each address as data,
// and a scoreboard queue holds the PCs decode should see, in order.
module tb_fetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] RV    = 32'hFFFF_FFF8;

  logic             clk_i = 1'b0;
  logic             rstn_i;
  logic             imem_req_o;
  logic [XLEN-1:0]  imem_addr_o;
  logic [31:0]      imem_rdata_i;
  logic             redirect_i;
  logic [XLEN-1:0]  redirect_pc_i;
  logic             halt_i;
  logic             instr_valid_o;
  logic [31:0]      instr_o;
  logic [XLEN-1:0]  instr_pc_o;
  logic             instr_ready_i;
  logic [CNT_W-1:0] count_o;
  logic             idle_o;

  fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o),
    .idle_o        (idle_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;
  logic        m_req;
  logic [31:0] m_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Memory answers exactly one cycle after a request, data = address.
  always begin
    @(negedge clk_i);
    m_req  = imem_req_o;
    m_addr = imem_addr_o;
    @(posedge clk_i);
    #1;
    imem_rdata_i = m_req ? m_addr : 32'hDEAD_BEEF;
  end

  // Scoreboard monitor: every head handshake must match the next expected PC.
  always @(negedge clk_i) begin
    check("count_le_depth", 32'(count_o > CNT_W'(DEPTH)), 32'd0);
    if (instr_valid_o && instr_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underrun: got pc %h, expected no instruction", instr_pc_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_pc", instr_pc_o, mon_exp);
        check("sb_instr", instr_o, mon_exp);
        n_pops++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn_i        = 1'b0;
    instr_ready_i = 1'b1;
    halt_i        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;

    // Reset state
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_req",   32'(imem_req_o),    32'd0);
    check("rst_addr",  imem_addr_o,        RV);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_count", 32'(count_o),       32'd0);
    check("rst_idle",  32'(idle_o),        32'd0);
    check("rst_instr", instr_o,            32'd0);
    check("rst_pc",    instr_pc_o,         32'd0);

    // Release with wrap-around from the reset vector
    next_cycle(); rstn_i = 1'b1; push_seq(RV, 30);             // C0
    @(negedge clk_i);
    check("c0_valid", 32'(instr_valid_o), 32'd0);
    check("c0_req",   32'(imem_req_o),    32'd1);
    check("c0_addr",  imem_addr_o,        32'hFFFF_FFF8);
    next_cycle(); @(negedge clk_i);                           // C1
    check("c1_valid", 32'(instr_valid_o), 32'd0);
    check("c1_addr",  imem_addr_o,        32'hFFFF_FFFC);
    next_cycle(); @(negedge clk_i);                           // C2
    check("c2_valid", 32'(instr_valid_o), 32'd1);
    check("c2_addr",  imem_addr_o,        32'h0000_0000);
    next_cycle(); @(negedge clk_i);                           // C3
    check("c3_addr",  imem_addr_o,        32'h0000_0004);
    run(4);                                                   // C7

    // Consumer stall for 10 cycles
    next_cycle(); instr_ready_i = 1'b0;                       // C8
    run(9);                                                   // C17
    @(negedge clk_i);
    check("stall_count", 32'(count_o),    32'd4);
    check("stall_req",   32'(imem_req_o), 32'd0);
    check("stall_head",  instr_pc_o,      32'h0000_0010);
    next_cycle(); instr_ready_i = 1'b1;                       // C18
    run(7);                                                   // C25

    // Redirect with 3 buffered and 1 in flight
    next_cycle();                                             // C26
    instr_ready_i = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    exp_q.delete();
    push_seq(32'h0000_0100, 20);
    @(negedge clk_i);
    check("redir_pre_count", 32'(count_o),    32'd3);
    check("redir_req",       32'(imem_req_o), 32'd0);
    next_cycle(); redirect_i = 1'b0; instr_ready_i = 1'b1;    // C27
    @(negedge clk_i);
    check("redir_count", 32'(count_o),       32'd0);
    check("redir_addr",  imem_addr_o,        32'h0000_0100);
    check("redir_req1",  32'(imem_req_o),    32'd1);
    check("redir_valid", 32'(instr_valid_o), 32'd0);
    run(7);                                                   // C34

    // Halt mid-stream
    next_cycle(); halt_i = 1'b1; instr_ready_i = 1'b0;        // C35
    @(negedge clk_i);
    check("halt_count0", 32'(count_o),    32'd1);
    check("halt_req",    32'(imem_req_o), 32'd0);
    check("halt_idle0",  32'(idle_o),     32'd0);
    next_cycle(); @(negedge clk_i);                           // C36
    check("halt_count1", 32'(count_o),    32'd2);
    check("halt_idle1",  32'(idle_o),     32'd0);
    check("halt_req1",   32'(imem_req_o), 32'd0);
    next_cycle(); instr_ready_i = 1'b1;                       // C37
    next_cycle(); @(negedge clk_i);                           // C38
    check("halt_idle2",  32'(idle_o),     32'd0);
    next_cycle(); @(negedge clk_i);                           // C39
    check("halt_idle3",  32'(idle_o),     32'd1);
    check("halt_count3", 32'(count_o),    32'd0);
    next_cycle(); halt_i = 1'b0;                              // C40
    @(negedge clk_i);
    check("resume_req",  32'(imem_req_o), 32'd1);
    check("resume_addr", imem_addr_o,     32'h0000_0120);
    check("resume_idle", 32'(idle_o),     32'd0);
    run(4);                                                   // C44

    // One-cycle reset with a request in flight
    next_cycle(); rstn_i = 1'b0; instr_ready_i = 1'b0;        // C45
    exp_q.delete();
    push_seq(RV, 4);
    next_cycle(); rstn_i = 1'b1; instr_ready_i = 1'b1;        // C46
    @(negedge clk_i);
    check("mrst_count", 32'(count_o),       32'd0);
    check("mrst_valid", 32'(instr_valid_o), 32'd0);
    check("mrst_instr", instr_o,            32'd0);
    check("mrst_addr",  imem_addr_o,        RV);
    check("mrst_req",   32'(imem_req_o),    32'd1);
    run(5);                                                   // C51
    @(negedge clk_i);
    next_cycle();

    check("handshakes", 32'(n_pops),       32'd29);
    check("sb_empty",   32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
